// File: rtl/lift_step_seq.sv
// One 5/3 lifting pass over a row in the pixel RAM: reads left/centre/right, writes the result in place.
// Build option: define LIFT_SAT_EN to saturate the result; otherwise it wraps to W bits.
//
// state  | meaning
// IDLE   | waiting for start; done pulses here for one cycle after a pass
// RD_L   | left neighbour address presented on rd_addr
// RD_P   | centre address presented; left data captured
// RD_R   | right neighbour address presented; centre data captured
// CAP    | right data arrives; result computed and registered
// WR     | result written to the centre address
module lift_step_seq #(
   parameter int W      = 26,
   parameter int ADDR_W = 7,
   parameter int N      = 128
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              pix_fwd_inv_i,
   input  logic              pix_even_odd_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [W-1:0]      rd_data_i,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [W-1:0]      wr_data_o,
   output logic              we_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_L,
      S_RD_P,
      S_RD_R,
      S_CAP,
      S_WR
   } state_t;

   localparam logic [ADDR_W-1:0] A_LAST_ODD  = ADDR_W'(N - 1);
   localparam logic [ADDR_W-1:0] A_LAST_EVEN = ADDR_W'(N - 2);
   localparam logic [ADDR_W-1:0] A_STEP      = ADDR_W'(2);
   localparam logic signed [W+1:0] RND_UPD   = (W + 2)'(2);

   // symmetric extension at both row ends
   function automatic logic [ADDR_W-1:0] left_of(input logic [ADDR_W-1:0] a);
      return (a == '0) ? ADDR_W'(1) : a - ADDR_W'(1);
   endfunction

   function automatic logic [ADDR_W-1:0] right_of(input logic [ADDR_W-1:0] a);
      return (a == A_LAST_ODD) ? A_LAST_EVEN : a + ADDR_W'(1);
   endfunction

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   a_q, a_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                fwd_q, fwd_d;
   logic                pred_q, pred_d;
   logic [W-1:0]        l_q, l_d;
   logic [W-1:0]        p_q, p_d;
   logic [W-1:0]        wr_data_q, wr_data_d;
   logic                done_q, done_d;

   logic [ADDR_W-1:0]   a_first;
   logic                last_sample;
   logic                add_d;
   logic signed [W:0]   s_w;
   logic signed [W+1:0] s_p2;
   logic [W-1:0]        d_w;
   logic [W-1:0]        lift_res;

   assign a_first     = {{(ADDR_W-1){1'b0}}, pix_even_odd_i};
   assign last_sample = pred_q ? (a_q == A_LAST_ODD) : (a_q == A_LAST_EVEN);

   // in CAP the right neighbour is still on rd_data, so it feeds the sum directly
   assign s_w   = $signed({l_q[W-1], l_q}) + $signed({rd_data_i[W-1], rd_data_i});
   assign s_p2  = $signed({s_w[W], s_w}) + RND_UPD;
   assign d_w   = pred_q ? W'(s_w >>> 1) : W'(s_p2 >>> 2);
   assign add_d = fwd_q ^ pred_q;

`ifdef LIFT_SAT_EN
   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   logic [W:0] res_x;

   assign res_x = add_d ? ({p_q[W-1], p_q} + {d_w[W-1], d_w})
                        : ({p_q[W-1], p_q} - {d_w[W-1], d_w});

   always_comb begin
      lift_res = res_x[W-1:0];
      if (res_x[W] != res_x[W-1]) begin
         lift_res = res_x[W] ? SAT_MIN : SAT_MAX;
      end
   end
`else
   assign lift_res = add_d ? (p_q + d_w) : (p_q - d_w);
`endif

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      rd_addr_d = rd_addr_q;
      fwd_d     = fwd_q;
      pred_d    = pred_q;
      l_d       = l_q;
      p_d       = p_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               fwd_d     = pix_fwd_inv_i;
               pred_d    = pix_even_odd_i;
               a_d       = a_first;
               rd_addr_d = left_of(a_first);
               state_d   = S_RD_L;
            end
         end
         S_RD_L: begin
            rd_addr_d = a_q;
            state_d   = S_RD_P;
         end
         S_RD_P: begin
            l_d       = rd_data_i;
            rd_addr_d = right_of(a_q);
            state_d   = S_RD_R;
         end
         S_RD_R: begin
            p_d     = rd_data_i;
            state_d = S_CAP;
         end
         S_CAP: begin
            wr_data_d = lift_res;
            state_d   = S_WR;
         end
         S_WR: begin
            if (last_sample) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               a_d       = a_q + A_STEP;
               rd_addr_d = left_of(a_q + A_STEP);
               state_d   = S_RD_L;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         rd_addr_q <= '0;
         fwd_q     <= 1'b0;
         pred_q    <= 1'b0;
         l_q       <= '0;
         p_q       <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         rd_addr_q <= rd_addr_d;
         fwd_q     <= fwd_d;
         pred_q    <= pred_d;
         l_q       <= l_d;
         p_q       <= p_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
      end
   end

   assign rd_addr_o = rd_addr_q;
   assign wr_addr_o = a_q;
   assign wr_data_o = wr_data_q;
   assign we_o      = (state_q == S_WR);
   assign busy_o    = (state_q != S_IDLE);
   assign done_o    = done_q;

endmodule

// File: tb/tb_lift_step_seq.sv
// Bench for lift_step_seq on an 8-sample row: directed test-plan passes, reset mid-pass and random passes.
// Reference is a plain per-row lifting model; LIFT_SAT_EN selects saturating or wrapping expectations.
module tb_lift_step_seq;

   localparam int W    = 26;
   localparam int AW   = 7;
   localparam int N    = 8;
   localparam int IW   = 3;
   localparam int LAST = 5 * (N / 2);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          fwd_i;
   logic          pred_i;
   logic [AW-1:0] rd_addr;
   logic [W-1:0]  rd_data;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic          we;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   logic signed [W-1:0] mem      [N];
   logic signed [W-1:0] load_buf [N];
   logic                load_req = 1'b0;
   longint              ref_m    [N];

   always #5 clk = ~clk;

   lift_step_seq #(.W(W), .ADDR_W(AW), .N(N)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .start_i        (start),
      .pix_fwd_inv_i  (fwd_i),
      .pix_even_odd_i (pred_i),
      .rd_addr_o      (rd_addr),
      .rd_data_i      (rd_data),
      .wr_addr_o      (wr_addr),
      .wr_data_o      (wr_data),
      .we_o           (we),
      .busy_o         (busy),
      .done_o         (done)
   );

   // pixel RAM: synchronous read, write lands on the same edge
   always @(posedge clk) begin
      rd_data <= mem[rd_addr[IW-1:0]];
      if (load_req) begin
         for (int i = 0; i < N; i++) mem[i] <= load_buf[i];
      end else if (we) begin
         mem[wr_addr[IW-1:0]] <= wr_data;
      end
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int lft(input int a);
      return (a == 0) ? 1 : a - 1;
   endfunction

   function automatic int rgt(input int a);
      return (a == N - 1) ? N - 2 : a + 1;
   endfunction

   function automatic longint floor_div(input longint x, input longint d);
      longint q;
      q = x / d;
      if ((x % d != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint reduce(input longint v);
      longint lim;
      longint m;
      lim = longint'(1) << (W - 1);
`ifdef LIFT_SAT_EN
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
`else
      m = v % (2 * lim);
      if (m < 0) m = m + 2 * lim;
      if (m >= lim) m = m - 2 * lim;
      return m;
`endif
   endfunction

   task automatic model_pass(input bit fwd, input bit pred, input int nsamp);
      int a;
      longint s, d, r;
      a = pred ? 1 : 0;
      for (int k = 0; k < nsamp; k++) begin
         s = ref_m[lft(a)] + ref_m[rgt(a)];
         if (pred) begin
            d = floor_div(s, 2);
            r = fwd ? ref_m[a] - d : ref_m[a] + d;
         end else begin
            d = floor_div(s + 2, 4);
            r = fwd ? ref_m[a] + d : ref_m[a] - d;
         end
         ref_m[a] = reduce(r);
         a = a + 2;
      end
   endtask

   task automatic commit_load();
      for (int i = 0; i < N; i++) ref_m[i] = load_buf[i];
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic check_ram();
      for (int i = 0; i < N; i++) chk($sformatf("ram[%0d]", i), mem[i], ref_m[i]);
   endtask

   // start is driven at the current negedge (cycle 0); returns at the done cycle's negedge
   task automatic run_pass(input bit fwd, input bit pred, input bit noisy);
      int a0, k, ph, a;
      a0 = pred ? 1 : 0;
      start  = 1'b1;
      fwd_i  = fwd;
      pred_i = pred;
      for (int i = 1; i <= LAST + 1; i++) begin
         @(negedge clk);
         chk("busy", busy, longint'(i <= LAST));
         chk("done", done, longint'(i == LAST + 1));
         chk("we", we, longint'((i % 5 == 0) && (i <= LAST)));
         if (i <= LAST) begin
            k  = (i - 1) / 5;
            ph = (i - 1) % 5;
            a  = a0 + 2 * k;
            case (ph)
               0:       chk("rd_addr_left", rd_addr, lft(a));
               1:       chk("rd_addr_centre", rd_addr, a);
               default: chk("rd_addr_right", rd_addr, rgt(a));
            endcase
            if (ph == 4) chk("wr_addr", wr_addr, a);
         end
         if (noisy && (i < LAST)) begin
            start  = 1'($urandom_range(0, 1));
            fwd_i  = 1'($urandom);
            pred_i = 1'($urandom);
         end else begin
            start = 1'b0;
         end
      end
   endtask

   function automatic logic signed [W-1:0] rnd_val();
      logic [31:0] u;
      u = $urandom;
      case ($urandom_range(0, 2))
         0:       return W'(int'($urandom_range(0, 200)) - 100);
         1:       return u[W-1:0];
         default: return u[0] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
      endcase
   endfunction

   longint exp_fp [N] = '{0, 0, 20, 0, 40, 0, 60, 10};
   longint exp_fu [N] = '{0, 0, 20, 0, 40, 0, 63, 10};
   longint ovf_exp;
   bit     rf, rp;

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      fwd_i  = 1'b0;
      pred_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;

      // forward predict, forward update, then both inverses back to the original row
      for (int i = 0; i < N; i++) load_buf[i] = W'(10 * i);
      commit_load();
      run_pass(1'b1, 1'b1, 1'b0);
      model_pass(1'b1, 1'b1, N / 2);
      check_ram();
      for (int i = 0; i < N; i++) chk($sformatf("fwd_pred[%0d]", i), mem[i], exp_fp[i]);
      run_pass(1'b1, 1'b0, 1'b0);
      model_pass(1'b1, 1'b0, N / 2);
      check_ram();
      for (int i = 0; i < N; i++) chk($sformatf("fwd_upd[%0d]", i), mem[i], exp_fu[i]);
      run_pass(1'b0, 1'b0, 1'b1);
      model_pass(1'b0, 1'b0, N / 2);
      check_ram();
      run_pass(1'b0, 1'b1, 1'b1);
      model_pass(1'b0, 1'b1, N / 2);
      check_ram();
      for (int i = 0; i < N; i++) chk($sformatf("roundtrip[%0d]", i), mem[i], 10 * i);

      // negative rounding: L=-3, P=0, R=0
      for (int i = 0; i < N; i++) load_buf[i] = '0;
      load_buf[0] = -W'(3);
      commit_load();
      run_pass(1'b1, 1'b1, 1'b0);
      model_pass(1'b1, 1'b1, N / 2);
      chk("neg_round", mem[1], 2);
      check_ram();

      // overflow: P = 2^25-1, L+R = -4
      for (int i = 0; i < N; i++) load_buf[i] = '0;
      load_buf[0] = -W'(4);
      load_buf[1] = {1'b0, {(W-1){1'b1}}};
      commit_load();
      run_pass(1'b1, 1'b1, 1'b0);
      model_pass(1'b1, 1'b1, N / 2);
`ifdef LIFT_SAT_EN
      ovf_exp = (longint'(1) << 25) - 1;
`else
      ovf_exp = -(longint'(1) << 25) + 1;
`endif
      chk("overflow", mem[1], ovf_exp);
      check_ram();

      // reset at cycle 8 of a pass, restart at cycle 12
      for (int i = 0; i < N; i++) load_buf[i] = W'(7 * i + 3);
      commit_load();
      start  = 1'b1;
      fwd_i  = 1'b1;
      pred_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      model_pass(1'b1, 1'b1, 1);
      for (int i = 9; i <= 12; i++) begin
         @(negedge clk);
         rst = 1'b0;
         chk("rst_mid_busy", busy, 0);
         chk("rst_mid_we", we, 0);
         chk("rst_mid_done", done, 0);
      end
      check_ram();
      run_pass(1'b1, 1'b1, 1'b1);
      model_pass(1'b1, 1'b1, N / 2);
      check_ram();

      // random rows and modes, with start and mode noise while busy
      for (int r = 0; r < 12; r++) begin
         if (r % 3 == 0) begin
            for (int i = 0; i < N; i++) load_buf[i] = rnd_val();
            commit_load();
         end
         rf = 1'($urandom);
         rp = 1'($urandom);
         run_pass(rf, rp, 1'b1);
         model_pass(rf, rp, N / 2);
         check_ram();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
